seg_bcd_mux: RTL and testbench
==============================

# seg_bcd_mux

Parametrised multi-digit 7-segment BCD display driver; generalises the fixed two-digit BCD display path to DIGITS digits. Captures a packed BCD/hex word through a valid/ready handshake and applies it only at frame boundaries, so a frame never mixes old and new digits. Decodes each nibble and time-multiplexes the common-select lines. Supports per-digit decimal points, a display blank control and optional leading-zero blanking; sits between value-producing logic (counters, ROM readout) and the board's seg_sel/seg_data pins.

## Interface
- DIGITS, 6, number of digits, 1..8; width of seg_sel.
- SCAN_DIV, 50000, clk cycles each digit is held (1 ms at 50 MHz); must be ≥ 2.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  4*DIGITS  packed nibbles; din[4i+3:4i] is digit i, digit 0 = least significant.
- din_valid  input  1  din is offered.
- din_ready  output  1  block can accept din this cycle.
- dp_mask  input  DIGITS  bit i = 1 lights the decimal point of digit i; sampled live, not shadowed.
- blank  input  1  1 = all digits off; scanning continues.
- frame_start  output  1  one-cycle pulse when digit 0 is selected.
- seg_sel  output  DIGITS  active-low digit select; exactly one bit low when displaying.
- seg_data  output  8  active-low {dp,g,f,e,d,c,b,a}.

## Operation
- Prescaler counts 0..SCAN_DIV-1, wraps, and asserts an internal tick on terminal count. Digit index 0..DIGITS-1 advances on tick and wraps DIGITS-1 -> 0.
- Handshake: transfer on din_valid && din_ready. din is captured into a pending register; din_ready drops the following cycle and stays low while pending is full. din_valid may be held; it is not consumed again until din_ready returns.
- Frame commit: on the tick that wraps the index to 0, a full pending register is copied into the shadow register, pending is cleared, and din_ready rises the next cycle. A transfer in the same cycle as the commit goes into pending; the committed value is the previous pending value, and din_ready stays low.
- Decoder, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex). Nibbles A–F are shown as hex letters, not rejected.
- seg_data = {~dp_mask[idx], decode(shadow digit idx)}.
- seg_sel = ~(1 << idx) when blank = 0; all ones when blank = 1.
- frame_start pulses in the cycle in which the index becomes 0.

## Timing
- Reset values: seg_sel all ones, seg_data 8'hFF, din_ready 1, frame_start 0, shadow 0, pending empty, index 0, prescaler 0.
- Outputs are registered. seg_sel and seg_data change in the cycle after a tick, or the cycle after a change on blank or dp_mask.
- First digit is displayed SCAN_DIV+1 cycles after reset release, showing digit 1. Index 0 returns after DIGITS·SCAN_DIV cycles.
- din latency: transfer at cycle N -> shown from the first frame commit after N. Worst case ≈ DIGITS·SCAN_DIV + 2 cycles.
- Reset mid-operation: all state returns to reset values immediately. A pending value is discarded.
- DIGITS = 1: every tick is a frame boundary.

## Configuration
- SEG_LZB_EN defined: in the shadow word, zero digits from DIGITS-1 down to the first nonzero digit are blanked (segments 7'h7F). Digit 0 is never blanked. Each blanked digit's dp still follows dp_mask. Blanking is evaluated on shadow contents, so it changes only at a commit.
- SEG_LZB_EN undefined: every digit is decoded; zeros show as "0".

## Test plan
- Reset with DIGITS=6, SCAN_DIV=4 -> seg_sel=6'b111111, seg_data=8'hFF, din_ready=1. After release, seg_sel sequence 111101, 111011, … 111110, each held 4 cycles. frame_start pulses once every 24 cycles.
- Load din=24'h123456, dp_mask=6'b000100 -> at the next frame, digit 0 shows seg_data=8'h82 and digit 2 shows 8'h19 with dp low. din_ready is low from the load until the cycle after the commit.
- Mid-frame offer of 24'h999999, then 24'h000000 held valid -> the first value is shown for one full frame. The second is accepted only after din_ready returns. No frame shows mixed digits.
- blank=1 for 10 cycles -> seg_sel=all ones the cycle after, and the scan index keeps advancing. On release, the digit scheduled at that time appears the cycle after.
- With SEG_LZB_EN defined, din=24'h000705 -> digits 5,4,3 give seg_data=8'hFF, digit 2 gives 8'hF8, digit 0 gives 8'h92. din=0 -> digit 0 gives 8'hC0.
- Assert rst_n low while pending is full -> outputs return to reset values asynchronously. After release, shadow=0 and the pending value never appears.

Source files
------------

// File: rtl/seg_bcd_mux.sv
// seg_bcd_mux: multi-digit 7-segment BCD/hex display driver with frame-aligned value updates.
// Optional feature macro SEG_LZB_EN: blank leading zero digits of the displayed word.
module seg_bcd_mux #(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [7:0]            seg_data
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         scanCnt_q, scanCnt_d;
    logic [IW-1:0]         digitIdx_q, digitIdx_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pendFull_q, pendFull_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  started_q, started_d;
    logic                  frameStart_q, frameStart_d;
    logic [DIGITS-1:0]     segSel_q, segSel_d;
    logic [7:0]            segData_q, segData_d;

    logic                  tick;
    logic                  wrap;
    logic                  accept;
    logic                  commit;
    logic [3:0]            curNib;
    logic                  curDp;
    logic                  curLzb;
    logic [DIGITS-1:0]     lzbMask;

    function automatic logic [6:0] decodeNibble(input logic [3:0] nib);
        case (nib)
            4'h0:    decodeNibble = 7'h40;
            4'h1:    decodeNibble = 7'h79;
            4'h2:    decodeNibble = 7'h24;
            4'h3:    decodeNibble = 7'h30;
            4'h4:    decodeNibble = 7'h19;
            4'h5:    decodeNibble = 7'h12;
            4'h6:    decodeNibble = 7'h02;
            4'h7:    decodeNibble = 7'h78;
            4'h8:    decodeNibble = 7'h00;
            4'h9:    decodeNibble = 7'h10;
            4'hA:    decodeNibble = 7'h08;
            4'hB:    decodeNibble = 7'h03;
            4'hC:    decodeNibble = 7'h46;
            4'hD:    decodeNibble = 7'h21;
            4'hE:    decodeNibble = 7'h06;
            4'hF:    decodeNibble = 7'h0E;
            default: decodeNibble = 7'h7F;
        endcase
    endfunction

`ifdef SEG_LZB_EN
    // A digit is blanked while it and every digit above it are zero; digit 0 always shows.
    logic lzbRun;
    always_comb begin
        lzbMask = '0;
        lzbRun  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lzbRun     = lzbRun && (shadow_q[4*i +: 4] == 4'h0);
            lzbMask[i] = lzbRun;
        end
    end
`else
    assign lzbMask = '0;
`endif

    always_comb begin
        curNib = 4'h0;
        curDp  = 1'b0;
        curLzb = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digitIdx_q == IW'(i)) begin
                curNib = shadow_q[4*i +: 4];
                curDp  = dp_mask[i];
                curLzb = lzbMask[i];
            end
        end
    end

    always_comb begin
        tick       = (scanCnt_q == CW'(SCAN_DIV - 1));
        wrap       = tick && (digitIdx_q == IW'(DIGITS - 1));
        accept     = din_valid && !pendFull_q;
        commit     = wrap && pendFull_q;

        scanCnt_d  = tick ? '0 : scanCnt_q + CW'(1);
        digitIdx_d = digitIdx_q;
        if (tick) begin
            digitIdx_d = wrap ? '0 : digitIdx_q + IW'(1);
        end

        // The committed word is always the one already pending, so a same-cycle transfer refills pending.
        shadow_d   = commit ? pend_q : shadow_q;
        pend_d     = accept ? din : pend_q;
        pendFull_d = accept || (pendFull_q && !commit);

        started_d    = started_q || tick;
        frameStart_d = wrap;

        segSel_d  = (blank || !started_q) ? '1 : ~(DIGITS'(1) << digitIdx_q);
        segData_d = 8'hFF;
        if (started_q) begin
            segData_d = {~curDp, curLzb ? 7'h7F : decodeNibble(curNib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanCnt_q    <= '0;
            digitIdx_q   <= '0;
            pend_q       <= '0;
            pendFull_q   <= 1'b0;
            shadow_q     <= '0;
            started_q    <= 1'b0;
            frameStart_q <= 1'b0;
            segSel_q     <= '1;
            segData_q    <= 8'hFF;
        end else begin
            scanCnt_q    <= scanCnt_d;
            digitIdx_q   <= digitIdx_d;
            pend_q       <= pend_d;
            pendFull_q   <= pendFull_d;
            shadow_q     <= shadow_d;
            started_q    <= started_d;
            frameStart_q <= frameStart_d;
            segSel_q     <= segSel_d;
            segData_q    <= segData_d;
        end
    end

    assign din_ready   = !pendFull_q;
    assign frame_start = frameStart_q;
    assign seg_sel     = segSel_q;
    assign seg_data    = segData_q;

endmodule

// File: tb/tb_seg_bcd_mux.sv
// tb_seg_bcd_mux: directed and random stimulus against a cycle-count reference model of the display driver.
// Leading-zero expectations follow SEG_LZB_EN so the bench matches either build.
module tb_seg_bcd_mux;

    localparam int D     = 6;
    localparam int SD    = 4;
    localparam int FRAME = D * SD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*D-1:0]  din;
    logic            din_valid;
    logic            din_ready;
    logic [D-1:0]    dp_mask;
    logic            blank;
    logic            frame_start;
    logic [D-1:0]    seg_sel;
    logic [7:0]      seg_data;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since reset release, pending slot, displayed word.
    int              mK;
    logic            mPendFull;
    logic [4*D-1:0]  mPend;
    logic [4*D-1:0]  mShadow;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_bcd_mux #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dp_mask     (dp_mask),
        .blank       (blank),
        .frame_start (frame_start),
        .seg_sel     (seg_sel),
        .seg_data    (seg_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, mK);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4*D-1:0] d,
                                 input logic [D-1:0] dp, input logic b);
        din_valid = v;
        din       = d;
        dp_mask   = dp;
        blank     = b;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sel"},   32'(seg_sel),     32'(6'h3F));
        checkOutput({tag, "_data"},  32'(seg_data),    32'h0000_00FF);
        checkOutput({tag, "_ready"}, 32'(din_ready),   32'd1);
        checkOutput({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    function automatic logic [7:0] expectedData(input int showIdx, input logic [D-1:0] dp,
                                                input logic [4*D-1:0] word);
        logic [4*D-1:0] upper;
        logic [3:0]     nib;
        logic [6:0]     seg;
        upper = word >> (4 * showIdx);
        nib   = upper[3:0];
        seg   = segTab[nib];
`ifdef SEG_LZB_EN
        if (showIdx > 0 && upper == '0) seg = 7'h7F;
`endif
        return {~dp[showIdx], seg};
    endfunction

    // Advance one clock from a negedge, update the model, check all outputs #1 after the edge.
    task automatic stepCycle();
        logic           vNow, bNow, accNow, comNow, started;
        logic [4*D-1:0] dNow;
        logic [D-1:0]   dpNow, oneHot, expSel;
        logic [7:0]     expData;
        int             showIdx;
        vNow  = din_valid;
        dNow  = din;
        dpNow = dp_mask;
        bNow  = blank;
        @(posedge clk);
        mK++;
        started = (mK - 1) >= SD;
        showIdx = ((mK - 1) / SD) % D;
        oneHot  = D'(1) << showIdx;
        expSel  = (bNow || !started) ? '1 : ~oneHot;
        expData = started ? expectedData(showIdx, dpNow, mShadow) : 8'hFF;
        accNow  = vNow && !mPendFull;
        comNow  = ((mK % FRAME) == 0) && mPendFull;
        if (comNow) begin
            mShadow   = mPend;
            mPendFull = 1'b0;
        end
        if (accNow) begin
            mPend     = dNow;
            mPendFull = 1'b1;
        end
        #1;
        checkOutput("seg_sel",     32'(seg_sel),     32'(expSel));
        checkOutput("seg_data",    32'(seg_data),    32'(expData));
        checkOutput("din_ready",   32'(din_ready),   32'(!mPendFull));
        checkOutput("frame_start", 32'(frame_start), 32'((mK % FRAME) == 0));
        @(negedge clk);
    endtask

    task automatic modelReset();
        mK        = 0;
        mPendFull = 1'b0;
        mPend     = '0;
        mShadow   = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        modelReset();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        // Idle scan: sequence of selects and frame pulses.
        repeat (30) stepCycle();

        $display("[TB] load 123456 with dp on digit 2");
        applyStimulus(1'b1, 24'h123456, 6'b000100, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, 6'b000100, 1'b0);
        repeat (60) stepCycle();

        $display("[TB] mid-frame 999999 then 000000 held valid");
        repeat (5) stepCycle();
        applyStimulus(1'b1, 24'h999999, 6'b000000, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 24'h000000, 6'b000000, 1'b0);
        repeat (80) stepCycle();
        applyStimulus(1'b0, '0, 6'b000000, 1'b0);
        repeat (30) stepCycle();

        $display("[TB] blank for 10 cycles");
        applyStimulus(1'b0, '0, 6'b101010, 1'b1);
        repeat (10) stepCycle();
        applyStimulus(1'b0, '0, 6'b101010, 1'b0);
        repeat (20) stepCycle();

        $display("[TB] leading-zero words");
        applyStimulus(1'b1, 24'h000705, 6'b000000, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, 6'b000000, 1'b0);
        repeat (50) stepCycle();
        applyStimulus(1'b1, 24'h000000, 6'b010001, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, 6'b010001, 1'b0);
        repeat (50) stepCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), 24'($urandom()),
                          ($urandom_range(0, 15) == 0) ? D'($urandom()) : dp_mask,
                          ($urandom_range(0, 19) == 0) ? ~blank : blank);
            stepCycle();
        end
        applyStimulus(1'b0, '0, dp_mask, 1'b0);
        repeat (10) stepCycle();

        $display("[TB] reset while pending is full");
        applyStimulus(1'b1, 24'hABCDEF, 6'b111111, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, 6'b111111, 1'b0);
        stepCycle();
        checkOutput("pending_full", 32'(din_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        modelReset();
        repeat (2) @(negedge clk);
        checkResetValues("held_reset");
        rst_n = 1'b1;
        repeat (60) stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
